// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The queue uses the slave view; the surrounding fetch/decode environment uses master.
interface if_id_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;

    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_bubble;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_bubble
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_bubble
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction queue: holds fetched {pc, inst} pairs, freezes the head
// on a hazard hold and empties itself (presenting a NOP bubble) on a branch/jump flush.
module if_id_queue #(
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 2,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h00000033),
    localparam int                CNT_W    = $clog2(DEPTH + 1),
    localparam int                PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    if_id_queue_if.slave     bus,
    input  logic             hold,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic bubble;
    logic push;
    logic pop;

    // Full/empty come from count alone, so in_ready never sees out_ready, hold or flush.
    assign bus.in_ready = (count != CNT_W'(DEPTH));

    assign bubble         = (count == '0) || hold || flush;
    assign bus.out_valid  = !bubble;
    assign bus.out_bubble = bubble;
    assign bus.out_inst   = bubble ? NOP_INST : mem_inst[rd_ptr];
    assign bus.out_pc     = (count == '0) ? '0 : mem_pc[rd_ptr];

    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready;

    // NOTE: the entry storage sits inside the async-reset block on purpose, so a reset
    // leaves no stale instruction visible; that costs reset fan-out on every storage flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]   <= bus.in_pc;
                mem_inst[wr_ptr] <= bus.in_inst;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a table of per-cycle vectors plus hand-written
// sequences for the idle-empty window and an asynchronous reset mid-stream.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h00000033;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic       flush;
    logic [1:0] count;

    int checks;
    int errors;

    if_id_queue_if #(.PC_W(32), .INST_W(32)) bus ();

    if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .hold  (hold),
        .flush (flush),
        .count (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        in_valid;
        logic [31:0] in_pc;
        logic [31:0] in_inst;
        logic        out_ready;
        logic        hold;
        logic        flush;
        logic        e_in_ready;
        logic        e_out_valid;
        logic [31:0] e_out_pc;
        logic [31:0] e_out_inst;
        logic        e_out_bubble;
        logic [1:0]  e_count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] ipc, input logic [31:0] iinst,
                                input logic ordy, input logic h, input logic f,
                                input logic erdy, input logic ev, input logic [31:0] epc,
                                input logic [31:0] einst, input logic eb, input logic [1:0] ec);
        vec_t v;
        v.in_valid = iv;  v.in_pc = ipc;  v.in_inst = iinst;
        v.out_ready = ordy;  v.hold = h;  v.flush = f;
        v.e_in_ready = erdy;  v.e_out_valid = ev;  v.e_out_pc = epc;
        v.e_out_inst = einst;  v.e_out_bubble = eb;  v.e_count = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ipc, input logic [31:0] iinst,
                         input logic ordy, input logic h, input logic f);
        bus.in_valid  = iv;
        bus.in_pc     = ipc;
        bus.in_inst   = iinst;
        bus.out_ready = ordy;
        hold          = h;
        flush         = f;
    endtask

    task automatic check_outputs(input string tag, input logic erdy, input logic ev,
                                 input logic [31:0] epc, input logic [31:0] einst,
                                 input logic eb, input logic [1:0] ec);
        check({tag, " in_ready"},   64'(bus.in_ready),   64'(erdy));
        check({tag, " out_valid"},  64'(bus.out_valid),  64'(ev));
        check({tag, " out_pc"},     64'(bus.out_pc),     64'(epc));
        check({tag, " out_inst"},   64'(bus.out_inst),   64'(einst));
        check({tag, " out_bubble"}, 64'(bus.out_bubble), 64'(eb));
        check({tag, " count"},      64'(count),          64'(ec));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Each vector: inputs held for one cycle; expectations are the outputs seen
        // during that cycle, i.e. before the edge that consumes the inputs.
        //              iv  in_pc   in_inst       ordy h  f    rdy ov out_pc  out_inst      bub cnt
        // Streaming with an always-ready consumer.
        vecs.push_back(mk(1, 32'h00, 32'h00100093, 1, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        vecs.push_back(mk(1, 32'h04, 32'h00200113, 1, 0, 0,  1, 1, 32'h00, 32'h00100093, 0, 1));
        vecs.push_back(mk(1, 32'h08, 32'h00300193, 1, 0, 0,  1, 1, 32'h04, 32'h00200113, 0, 1));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 0, 0,  1, 1, 32'h08, 32'h00300193, 0, 1));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        // Backpressure: fill to DEPTH, third entry waits at IF, then drain in order.
        vecs.push_back(mk(1, 32'h00, 32'h00100093, 0, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        vecs.push_back(mk(1, 32'h04, 32'h00200113, 0, 0, 0,  1, 1, 32'h00, 32'h00100093, 0, 1));
        vecs.push_back(mk(1, 32'h08, 32'h00300193, 0, 0, 0,  0, 1, 32'h00, 32'h00100093, 0, 2));
        vecs.push_back(mk(1, 32'h08, 32'h00300193, 1, 0, 0,  0, 1, 32'h00, 32'h00100093, 0, 2));
        vecs.push_back(mk(1, 32'h08, 32'h00300193, 1, 0, 0,  1, 1, 32'h04, 32'h00200113, 0, 1));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 0, 0,  1, 1, 32'h08, 32'h00300193, 0, 1));
        // Hold for two cycles with head at 0x10; a push is accepted during the hold.
        vecs.push_back(mk(1, 32'h10, 32'h00400213, 0, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 1, 0,  1, 0, 32'h10, NOP,          1, 1));
        vecs.push_back(mk(1, 32'h14, 32'h00500293, 1, 1, 0,  1, 0, 32'h10, NOP,          1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 0, 0, 0,  0, 1, 32'h10, 32'h00400213, 0, 2));
        // Flush while full with IF offering 0x20.
        vecs.push_back(mk(1, 32'h20, 32'h00600313, 1, 0, 1,  0, 0, 32'h10, NOP,          1, 2));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        // Flush with an accepted-looking push of 0x20: the push must be dropped.
        vecs.push_back(mk(1, 32'h40, 32'h00700393, 0, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        vecs.push_back(mk(1, 32'h20, 32'h00600313, 1, 0, 1,  1, 0, 32'h40, NOP,          1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        vecs.push_back(mk(1, 32'h40, 32'h00700393, 1, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 0, 0,  1, 1, 32'h40, 32'h00700393, 0, 1));
        // hold and flush together: the queue is emptied, not frozen.
        vecs.push_back(mk(1, 32'h44, 32'h00800413, 0, 0, 0,  1, 0, 32'h00, NOP,          1, 0));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 1, 1,  1, 0, 32'h44, NOP,          1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h00000000, 1, 0, 0,  1, 0, 32'h00, NOP,          1, 0));

        #1;
        check_outputs("reset", 1'b1, 1'b0, 32'h0, NOP, 1'b1, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in_valid, vecs[i].in_pc, vecs[i].in_inst,
                  vecs[i].out_ready, vecs[i].hold, vecs[i].flush);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].e_in_ready, vecs[i].e_out_valid,
                          vecs[i].e_out_pc, vecs[i].e_out_inst, vecs[i].e_out_bubble,
                          vecs[i].e_count);
        end

        // Empty queue with a ready consumer: nothing pops, count never underflows.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("idle%0d count", c),     64'(count),         64'd0);
            check($sformatf("idle%0d out_valid", c), 64'(bus.out_valid), 64'd0);
            check($sformatf("idle%0d out_inst", c),  64'(bus.out_inst),  64'(NOP));
        end

        // Fill to two entries, then assert reset between clock edges.
        @(negedge clk);
        drive(1'b1, 32'h50, 32'h00900493, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h54, 32'h00a00513, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_rst count",  64'(count),      64'd2);
        check("pre_rst out_pc", 64'(bus.out_pc), 64'h50);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b1, 1'b0, 32'h0, NOP, 1'b1, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_outputs("post_rst", 1'b1, 1'b0, 32'h0, NOP, 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the fixed IF/ID pipeline register: a DEPTH-entry instruction queue between fetch and decode.
- Accepts {pc, inst} pairs from IF under valid/ready handshake and presents the head entry to the decoder.
- Supports a hazard hold that freezes the head without corrupting it, and a branch/jump flush that empties the queue and injects a NOP bubble.
- Replaces the single register that reloads a NOP on stall and so loses the instruction.

Parameters:
- PC_W, 32, PC field width.
- INST_W, 32, instruction field width.
- DEPTH, 2, number of entries; power of two, 2..8.
- NOP_INST, 32'h00000033, bubble encoding (ADD x0,x0,x0); width INST_W.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF presents a fetched instruction.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_pc  in  PC_W  fetched PC.
- in_inst  in  INST_W  fetched instruction.
- out_valid  out  1  head instruction offered to ID.
- out_ready  in  1  ID consumes the head.
- out_pc  out  PC_W  head PC.
- out_inst  out  INST_W  head instruction, or NOP_INST when bubbling.
- out_bubble  out  1  out_inst is a NOP filler.
- hold  in  1  load-use stall from the hazard unit; freeze the head.
- flush  in  1  branch/jump taken in EX; discard all queued instructions.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (async, rst_n low):
  - count=0; read and write pointers=0; all entry storage cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_bubble=1, out_inst=NOP_INST, out_pc=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push: occurs on an edge where in_valid && in_ready && !flush. Data is written at the write pointer, and the write pointer increments mod DEPTH.
- Pop: occurs on an edge where out_valid && out_ready. The read pointer increments mod DEPTH.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full versus empty is resolved by count, never by pointer compare.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop together.
- Latency: an entry pushed into an empty queue appears on out_* the next cycle. There is no same-cycle bypass from in_* to out_*.
- in_ready depends only on count. There is no combinational path from out_ready, hold or flush to in_ready.
  - Full: in_ready=0, even when a pop occurs in the same cycle.
  - IF must hold in_pc/in_inst stable while in_valid && !in_ready.
- Output presentation (combinational from registered state plus hold/flush):
  - bubble = (count==0) || hold || flush.
  - out_valid = !bubble.
  - out_bubble = bubble.
  - out_inst = bubble ? NOP_INST : head inst.
  - out_pc = (count==0) ? 0 : head pc. Head pc is shown during hold and flush, so downstream logic has a PC for the bubble.
- hold: no pop. Head storage and pointers are unchanged, so the same instruction is re-presented when hold drops. Push is still permitted during hold if in_ready=1.
- flush:
  - Takes priority over hold, push and pop.
  - At the edge: count=0, read pointer = write pointer, and any same-cycle push is dropped.
  - In the flush cycle, out_valid=0 and out_inst=NOP_INST.
  - After the edge: queue empty, in_ready=1, bubble until the first post-flush push arrives, which appears one cycle later.
- hold && flush together: flush behaviour applies.
- Empty with out_ready=1: no pop, count stays 0 and never underflows.
- With DEPTH=2 and an always-ready consumer, the queue sustains 1 instruction/cycle after the first cycle.

Test Plan:
- Reset, then stream PCs 0x00,0x04,0x08 with insts 0x00100093,0x00200113,0x00300193, out_ready=1 -> each appears one cycle after push, out_valid=1, out_bubble=0, count toggles 1, no gaps.
- DEPTH=2, out_ready=0, push three entries -> count=2, in_ready=0 after the second push, the third is held by IF; raise out_ready -> order preserved (0x00,0x04,0x08), pointers wrap correctly.
- Head at PC 0x10, hold=1 for 2 cycles -> out_inst=0x00000033, out_bubble=1, out_pc=0x10, count unchanged; hold=0 -> original inst at 0x10 presented.
- count=2, flush=1 with a simultaneous push of PC 0x20 -> same cycle out_inst=NOP; next cycle count=0, in_ready=1, 0x20 absent; push 0x40 -> valid at out next cycle.
- hold=1 and flush=1 in the same cycle with count=1 -> queue emptied, not frozen; rst_n pulsed low mid-stream with count=2 -> count=0, out_pc=0, out_bubble=1 immediately.
- Empty queue with out_ready=1 for 5 cycles -> count stays 0, out_valid=0, out_inst=0x00000033.
